shaper_event_controller: RTL and testbench

//  Per-channel sequencer after the trapezoidal shaper. Measures the zero line, arms on a trigger,

---
 rtl/shaper_event_controller.sv | 215 +++++++++++++++++++++
 tb/tb_shaper_event_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shaper_event_controller.sv
// Per-channel event sequencer behind the trapezoidal shaper: baseline measurement, trigger arming,
// flat-top wait, maximum search, pile-up rejection and holdoff.
module shaper_event_controller #(
  parameter int unsigned SIZE_SHAPER_DATA         = 16,
  parameter int unsigned SIZE_TIME_MAXIMUM_SEARCH = 8,
  parameter int unsigned SIZE_EVENT_COUNTER       = 32,
  parameter int unsigned ZERO_LINE_LOG2           = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                counter_clear,
  input  logic [SIZE_TIME_MAXIMUM_SEARCH-1:0] peak_delay,
  input  logic [SIZE_TIME_MAXIMUM_SEARCH-1:0] search_time,
  input  logic [15:0]                         holdoff_time,
  input  logic [SIZE_SHAPER_DATA-1:0]         shaper_data,
  input  logic                                shaper_data_valid,
  input  logic                                trigger,
  output logic                                event_valid,
  output logic [SIZE_SHAPER_DATA-1:0]         event_energy,
  output logic                                event_pile_up,
  output logic [SIZE_SHAPER_DATA-1:0]         zero_line,
  output logic                                zero_line_valid,
  output logic                                busy,
  output logic [SIZE_EVENT_COUNTER-1:0]       event_counter,
  output logic [SIZE_EVENT_COUNTER-1:0]       pile_up_counter
);

  localparam int unsigned DW      = SIZE_SHAPER_DATA;
  localparam int unsigned SW      = SIZE_TIME_MAXIMUM_SEARCH;
  localparam int unsigned CW      = SIZE_EVENT_COUNTER;
  localparam int unsigned ACC_W   = SIZE_SHAPER_DATA + ZERO_LINE_LOG2;
  localparam int unsigned TIMER_W = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ZERO_LINE = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_WAIT_PEAK = 3'd3;
  localparam logic [2:0] S_SEARCH    = 3'd4;
  localparam logic [2:0] S_HOLDOFF   = 3'd5;

  logic [2:0]                state, state_nx;
  logic [ACC_W-1:0]          acc, acc_nx;
  logic [ZERO_LINE_LOG2-1:0] zl_cnt, zl_cnt_nx;
  logic [TIMER_W-1:0]        timer, timer_nx;
  logic [SW-1:0]             srch_len, srch_len_nx;
  logic [DW-1:0]             max_val, max_val_nx;
  logic                      max_seen, max_seen_nx;
  logic                      event_valid_nx, event_pile_up_nx, zero_line_valid_nx, busy_nx;
  logic [DW-1:0]             event_energy_nx, zero_line_nx;
  logic [CW-1:0]             event_counter_nx, pile_up_counter_nx;

  logic                      ev_inc, pu_inc, end_event;
  logic [ACC_W-1:0]          acc_sum;
  logic signed [ACC_W-1:0]   acc_shr;
  logic [SW-1:0]             srch_load;
  logic [DW-1:0]             cur_max;
  logic signed [DW:0]        diff;

  // State register plus all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      acc             <= '0;
      zl_cnt          <= '0;
      timer           <= '0;
      srch_len        <= '0;
      max_val         <= '0;
      max_seen        <= 1'b0;
      event_valid     <= 1'b0;
      event_energy    <= '0;
      event_pile_up   <= 1'b0;
      zero_line       <= '0;
      zero_line_valid <= 1'b0;
      busy            <= 1'b0;
      event_counter   <= '0;
      pile_up_counter <= '0;
    end else begin
      state           <= state_nx;
      acc             <= acc_nx;
      zl_cnt          <= zl_cnt_nx;
      timer           <= timer_nx;
      srch_len        <= srch_len_nx;
      max_val         <= max_val_nx;
      max_seen        <= max_seen_nx;
      event_valid     <= event_valid_nx;
      event_energy    <= event_energy_nx;
      event_pile_up   <= event_pile_up_nx;
      zero_line       <= zero_line_nx;
      zero_line_valid <= zero_line_valid_nx;
      busy            <= busy_nx;
      event_counter   <= event_counter_nx;
      pile_up_counter <= pile_up_counter_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx           = state;
    acc_nx             = acc;
    zl_cnt_nx          = zl_cnt;
    timer_nx           = timer;
    srch_len_nx        = srch_len;
    max_val_nx         = max_val;
    max_seen_nx        = max_seen;
    event_valid_nx     = 1'b0;
    event_energy_nx    = event_energy;
    event_pile_up_nx   = event_pile_up;
    zero_line_nx       = zero_line;
    zero_line_valid_nx = zero_line_valid;
    ev_inc             = 1'b0;
    pu_inc             = 1'b0;
    end_event          = 1'b0;

    acc_sum   = acc + {{ZERO_LINE_LOG2{shaper_data[DW-1]}}, shaper_data};
    acc_shr   = $signed(acc_sum) >>> ZERO_LINE_LOG2;
    srch_load = (search_time == '0) ? SW'(1) : search_time;
    cur_max   = (!max_seen || ($signed(shaper_data) > $signed(max_val))) ? shaper_data : max_val;
    diff      = $signed({cur_max[DW-1], cur_max}) - $signed({zero_line[DW-1], zero_line});

    if (!enable) begin
      state_nx           = S_IDLE;
      zero_line_valid_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx  = S_ZERO_LINE;
          acc_nx    = '0;
          zl_cnt_nx = '0;
        end
        S_ZERO_LINE: begin
          if (shaper_data_valid) begin
            acc_nx    = acc_sum;
            zl_cnt_nx = zl_cnt + 1'b1;
            if (&zl_cnt) begin
              zero_line_nx       = acc_shr[DW-1:0];
              zero_line_valid_nx = 1'b1;
              state_nx           = S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (shaper_data_valid && trigger) begin
            srch_len_nx = srch_load;
            max_seen_nx = 1'b0;
            if (peak_delay == '0) begin
              state_nx = S_SEARCH;
              timer_nx = TIMER_W'(srch_load);
            end else begin
              state_nx = S_WAIT_PEAK;
              timer_nx = TIMER_W'(peak_delay);
            end
          end
        end
        S_WAIT_PEAK: begin
          if (shaper_data_valid) begin
            if (trigger) begin
              pu_inc    = 1'b1;
              end_event = 1'b1;
            end else if (timer == TIMER_W'(1)) begin
              state_nx = S_SEARCH;
              timer_nx = TIMER_W'(srch_len);
            end else begin
              timer_nx = timer - 1'b1;
            end
          end
        end
        S_SEARCH: begin
          if (shaper_data_valid) begin
            if (trigger) begin
              pu_inc    = 1'b1;
              end_event = 1'b1;
            end else begin
              max_val_nx  = cur_max;
              max_seen_nx = 1'b1;
              if (timer == TIMER_W'(1)) begin
                ev_inc          = 1'b1;
                end_event       = 1'b1;
                event_energy_nx = diff[DW] ? '0 : diff[DW-1:0];
              end else begin
                timer_nx = timer - 1'b1;
              end
            end
          end
        end
        S_HOLDOFF: begin
          if (shaper_data_valid) begin
            if (timer == TIMER_W'(1)) state_nx = S_ARMED;
            else                      timer_nx = timer - 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // Accepted and rejected events share the pulse and the holdoff load
    if (end_event) begin
      event_valid_nx   = 1'b1;
      event_pile_up_nx = pu_inc;
      if (pu_inc) event_energy_nx = '0;
      if (holdoff_time == '0) begin
        state_nx = S_ARMED;
      end else begin
        state_nx = S_HOLDOFF;
        timer_nx = TIMER_W'(holdoff_time);
      end
    end

    event_counter_nx   = counter_clear ? '0 : event_counter + CW'(ev_inc);
    pile_up_counter_nx = counter_clear ? '0 : pile_up_counter + CW'(pu_inc);
    busy_nx            = (state_nx == S_WAIT_PEAK) || (state_nx == S_SEARCH) ||
                         (state_nx == S_HOLDOFF);
  end

endmodule

// File: tb/tb_shaper_event_controller.sv
// Directed bench for shaper_event_controller: expected events go to a queue when stimulus is
// driven and are popped by a monitor on each event_valid pulse.
module tb_shaper_event_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        counter_clear;
  logic [7:0]  peak_delay;
  logic [7:0]  search_time;
  logic [15:0] holdoff_time;
  logic [15:0] shaper_data;
  logic        shaper_data_valid;
  logic        trigger;
  logic        event_valid;
  logic [15:0] event_energy;
  logic        event_pile_up;
  logic [15:0] zero_line;
  logic        zero_line_valid;
  logic        busy;
  logic [31:0] event_counter;
  logic [31:0] pile_up_counter;

  typedef struct packed {
    logic [15:0] energy;
    logic        pile_up;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  shaper_event_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .counter_clear(counter_clear),
    .peak_delay(peak_delay), .search_time(search_time), .holdoff_time(holdoff_time),
    .shaper_data(shaper_data), .shaper_data_valid(shaper_data_valid), .trigger(trigger),
    .event_valid(event_valid), .event_energy(event_energy), .event_pile_up(event_pile_up),
    .zero_line(zero_line), .zero_line_valid(zero_line_valid), .busy(busy),
    .event_counter(event_counter), .pile_up_counter(pile_up_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every event pulse must match the oldest expectation
  always @(negedge clk) begin
    if (event_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed energy %0d pile_up %0d expected no event",
               event_energy, event_pile_up);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_energy", 32'(event_energy), 32'(e.energy));
        chk("event_pile_up", 32'(event_pile_up), 32'(e.pile_up));
      end
    end
  end

  task automatic sample(input logic [15:0] d, input logic t);
    shaper_data       = d;
    trigger           = t;
    shaper_data_valid = 1'b1;
    @(posedge clk); #1;
    shaper_data_valid = 1'b0;
    trigger           = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; counter_clear = 1'b0;
    peak_delay = 8'd3; search_time = 8'd4; holdoff_time = 16'd0;
    shaper_data = '0; shaper_data_valid = 1'b0; trigger = 1'b0;
    gap(2);
    chk("reset_zero_line_valid", 32'(zero_line_valid), 32'd0);
    chk("reset_event_counter", event_counter, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Baseline of +100 with gaps and an ignored trigger
    enable = 1'b1;
    gap(1);
    for (int i = 0; i < 255; i++) begin
      sample(16'd100, i == 10);
      if (i % 7 == 0) gap(1);
    end
    chk("zl_valid_before_last", 32'(zero_line_valid), 32'd0);
    sample(16'd100, 1'b0);
    chk("zl_valid_after_last", 32'(zero_line_valid), 32'd1);
    chk("zero_line_100", 32'(zero_line), 32'd100);
    chk("armed_not_busy", 32'(busy), 32'd0);

    // Normal event: max 900 - 100
    exp_q.push_back('{energy: 16'd800, pile_up: 1'b0});
    sample(16'd120, 1'b1);
    sample(16'd150, 1'b0); gap(1);
    sample(16'd300, 1'b0);
    sample(16'd500, 1'b0);
    sample(16'd800, 1'b0);
    sample(16'd900, 1'b0); gap(2);
    sample(16'd850, 1'b0);
    chk("event_not_yet", 32'(event_valid), 32'd0);
    sample(16'd700, 1'b0);
    chk("event_counter_1", event_counter, 32'd1);
    gap(2);

    // Pile-up on the second search sample
    exp_q.push_back('{energy: 16'd0, pile_up: 1'b1});
    sample(16'd120, 1'b1);
    sample(16'd150, 1'b0);
    sample(16'd300, 1'b0);
    sample(16'd500, 1'b0);
    sample(16'd800, 1'b0);
    sample(16'd900, 1'b1);
    chk("pile_up_counter_1", pile_up_counter, 32'd1);
    chk("event_counter_hold", event_counter, 32'd1);
    gap(1);

    // Holdoff of 10 after an accepted event, trigger mid-holdoff ignored
    holdoff_time = 16'd10;
    exp_q.push_back('{energy: 16'd200, pile_up: 1'b0});
    sample(16'd100, 1'b1);
    repeat (3) sample(16'd100, 1'b0);
    sample(16'd300, 1'b0);
    sample(16'd250, 1'b0);
    sample(16'd200, 1'b0);
    sample(16'd150, 1'b0);
    chk("event_counter_2", event_counter, 32'd2);
    for (int i = 1; i <= 10; i++) begin
      sample(16'd100, i == 5);
      if (i < 10) chk("holdoff_busy", 32'(busy), 32'd1);
    end
    chk("holdoff_done_armed", 32'(busy), 32'd0);

    // Accepted trigger right after holdoff; max below zero line clamps to 0
    exp_q.push_back('{energy: 16'd0, pile_up: 1'b0});
    sample(16'd100, 1'b1);
    chk("post_holdoff_trigger", 32'(busy), 32'd1);
    repeat (3) sample(16'd40, 1'b0);
    sample(16'd10, 1'b0);
    sample(16'd50, 1'b0);
    sample(16'hFFF0, 1'b0);
    sample(16'd20, 1'b0);
    chk("event_counter_3", event_counter, 32'd3);
    holdoff_time = 16'd0;

    // Re-measure at the negative limit, then the widest energy
    enable = 1'b0; gap(1);
    chk("disable_zl_valid", 32'(zero_line_valid), 32'd0);
    enable = 1'b1; gap(1);
    for (int i = 0; i < 256; i++) sample(16'h8000, 1'b0);
    chk("zero_line_min", 32'(zero_line), 32'h8000);
    exp_q.push_back('{energy: 16'd65535, pile_up: 1'b0});
    sample(16'd0, 1'b1);
    repeat (3) sample(16'd0, 1'b0);
    sample(16'h7FFF, 1'b0);
    repeat (3) sample(16'h8000, 1'b0);
    gap(1);

    // Drop enable mid-search: no event, baseline held but invalid
    sample(16'd0, 1'b1);
    repeat (3) sample(16'd0, 1'b0);
    sample(16'd500, 1'b0);
    sample(16'd600, 1'b0);
    enable = 1'b0; gap(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_zl_valid", 32'(zero_line_valid), 32'd0);
    chk("abort_zl_hold", 32'(zero_line), 32'h8000);
    sample(16'd700, 1'b0);
    gap(2);
    chk("abort_event_counter", event_counter, 32'd4);

    // Re-measure with a fractional mean (100.5 truncates to 100)
    enable = 1'b1; gap(1);
    for (int i = 0; i < 256; i++) sample((i % 2 == 0) ? 16'd101 : 16'd100, 1'b0);
    chk("remeasure_zl", 32'(zero_line), 32'd100);
    chk("remeasure_zl_valid", 32'(zero_line_valid), 32'd1);

    counter_clear = 1'b1; gap(1); counter_clear = 1'b0;
    chk("clear_event_counter", event_counter, 32'd0);
    chk("clear_pile_up_counter", pile_up_counter, 32'd0);

    // Asynchronous reset in WAIT_PEAK
    sample(16'd100, 1'b1);
    sample(16'd100, 1'b0);
    chk("wait_peak_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zero_line", 32'(zero_line), 32'd0);
    chk("rst_zl_valid", 32'(zero_line_valid), 32'd0);
    chk("rst_event_energy", 32'(event_energy), 32'd0);
    chk("rst_pile_up", 32'(event_pile_up), 32'd0);
    gap(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
